// File: rtl/fftl_ctrl.sv
// rtl/fftl_ctrl.sv - fine frequency-tracking loop sequencer for the oscillator control code
// Averages detector votes over a 2^k window, steps the code, then settles before the next window.
module fftl_ctrl #(
  parameter int CODE_W       = 13,
  parameter int ACC_W        = 16,
  parameter int MAX_WIN_LOG2 = 12,
  parameter int LOCK_TOGGLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fftl_en,
  input  logic [CODE_W-1:0] manual_control_osc,
  input  logic [3:0]        fine_con_step_size,
  input  logic [4:0]        fine_control_avg_window_select,
  input  logic [5:0]        div_ratio_half,
  input  logic              det_valid,
  input  logic              det_up,
  output logic [CODE_W-1:0] ctl_code,
  output logic              code_upd,
  output logic              lock,
  output logic              busy
);

  localparam int CNT_W = MAX_WIN_LOG2 + 1;
  localparam int TOG_W = $clog2(LOCK_TOGGLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, UPDATE, SETTLE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        samp_cnt;
  logic [CNT_W-1:0]        win_n;
  logic [3:0]              step_q;
  logic [4:0]              win_q;
  logic [6:0]              settle_cnt;
  logic [6:0]              settle_lim;
  logic [TOG_W-1:0]        tog_cnt, tog_nxt, tog_inc;
  dir_t                    last_dir, dir_nxt;
  logic                    win_done, enter_accum, acc_pos, acc_neg;
  logic [CODE_W:0]         code_up, code_dn;
  logic [CODE_W-1:0]       code_nxt;

  assign win_n      = CNT_W'(1) << win_q;
  assign win_done   = det_valid && ((samp_cnt + CNT_W'(1)) == win_n);
  assign settle_lim = {div_ratio_half, 1'b0} - 7'd1;
  assign acc_neg    = acc[ACC_W-1];
  assign acc_pos    = !acc[ACC_W-1] && (acc != '0);

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (fftl_en) state_nxt = LOAD;
      LOAD:    state_nxt = ACCUM;
      ACCUM:   if (win_done) state_nxt = UPDATE;
      UPDATE:  state_nxt = (div_ratio_half == '0) ? ACCUM : SETTLE;
      SETTLE:  if (settle_cnt == settle_lim) state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
    if (!fftl_en) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Step/window parameters and the accumulator are (re)armed on every entry into ACCUM.
  assign enter_accum = (state_nxt == ACCUM) && (state != ACCUM);

  always_comb begin
    code_up  = {1'b0, ctl_code} + (CODE_W+1)'(step_q);
    code_dn  = {1'b0, ctl_code} - (CODE_W+1)'(step_q);
    code_nxt = ctl_code;
    if (acc_pos)      code_nxt = code_up[CODE_W] ? '1 : code_up[CODE_W-1:0];
    else if (acc_neg) code_nxt = code_dn[CODE_W] ? '0 : code_dn[CODE_W-1:0];
  end

  always_comb begin
    tog_inc = (tog_cnt >= TOG_W'(LOCK_TOGGLES)) ? tog_cnt : tog_cnt + TOG_W'(1);
    tog_nxt = tog_cnt;
    dir_nxt = last_dir;
    if (last_dir == DIR_NONE) begin
      if (acc_pos)      dir_nxt = DIR_UP;
      else if (acc_neg) dir_nxt = DIR_DN;
    end else if (!acc_pos && !acc_neg) begin
      tog_nxt = tog_inc;
    end else if ((acc_pos && last_dir == DIR_DN) || (acc_neg && last_dir == DIR_UP)) begin
      tog_nxt = tog_inc;
      dir_nxt = acc_pos ? DIR_UP : DIR_DN;
    end else begin
      tog_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_code   <= '0;
      code_upd   <= 1'b0;
      lock       <= 1'b0;
      acc        <= '0;
      samp_cnt   <= '0;
      step_q     <= '0;
      win_q      <= '0;
      settle_cnt <= '0;
      tog_cnt    <= '0;
      last_dir   <= DIR_NONE;
    end else begin
      code_upd <= 1'b0;
      if (!fftl_en || state == IDLE || state == LOAD) begin
        ctl_code <= manual_control_osc;
      end else if (state == UPDATE) begin
        ctl_code <= code_nxt;
        code_upd <= 1'b1;
        tog_cnt  <= tog_nxt;
        last_dir <= dir_nxt;
        lock     <= (tog_nxt >= TOG_W'(LOCK_TOGGLES));
      end
      if (!fftl_en) lock <= 1'b0;

      if (state == LOAD) begin
        tog_cnt  <= '0;
        last_dir <= DIR_NONE;
      end

      if (enter_accum) begin
        acc      <= '0;
        samp_cnt <= '0;
        step_q   <= fine_con_step_size;
        win_q    <= (fine_control_avg_window_select > 5'(MAX_WIN_LOG2)) ?
                    5'(MAX_WIN_LOG2) : fine_control_avg_window_select;
      end else if (state == ACCUM && det_valid) begin
        acc      <= det_up ? acc + ACC_W'(1) : acc - ACC_W'(1);
        samp_cnt <= samp_cnt + CNT_W'(1);
      end

      if (state == UPDATE)      settle_cnt <= '0;
      else if (state == SETTLE) settle_cnt <= settle_cnt + 7'd1;
    end
  end

endmodule
